// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and width helpers for the FIFO control shell and its FIFO instances.
package fifo_ctrl_pkg;
  localparam int DEF_DATA_WIDTH   = 25;
  localparam int DEF_DEPTH        = 256;
  localparam int DEF_AFULL_THRESH = 240;

  typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} src_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_ctrl_if.sv
// Producer/consumer valid-ready streams around the FIFO control shell.
interface fifo_ctrl_if #(parameter int DATA_WIDTH = fifo_ctrl_pkg::DEF_DATA_WIDTH) ();
  logic [DATA_WIDTH-1:0] s0_data;
  logic                  s0_valid;
  logic                  s0_ready;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;
  logic                  s1_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport slave (
    input  s0_data, s0_valid, s1_data, s1_valid, m_ready,
    output s0_ready, s1_ready, m_data, m_valid
  );

  modport master (
    output s0_data, s0_valid, s1_data, s1_valid, m_ready,
    input  s0_ready, s1_ready, m_data, m_valid
  );
endinterface

// File: rtl/fifo_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; prio only moves when both sources contend for an enabled slot.
module rr_arb2
  import fifo_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] rdy,
  output src_e       sel
);
  src_e       prio_q, prio_d;
  logic [1:0] gnt;

  always_comb begin
    rdy[0] = en & (!req[1] | (prio_q == SRC0));
    rdy[1] = en & (!req[0] | (prio_q == SRC1));
    gnt    = req & rdy;
    sel    = gnt[1] ? SRC1 : SRC0;
  end

  always_comb begin
    prio_d = prio_q;
    if (clr)
      prio_d = SRC0;
    else if (en && (&req))
      prio_d = (prio_q == SRC0) ? SRC1 : SRC0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= SRC0;
    else        prio_q <= prio_d;
  end
endmodule

// File: rtl/fifo_ctrl.sv
// Control shell for a flagless circular-buffer FIFO: arbitrates two producers, tracks
// occupancy, and guards the FIFO against overflow/underflow and drives its reset/flush.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int AFULL_THRESH = DEF_AFULL_THRESH
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  fifo_ctrl_if.slave                bus,
  output logic [DATA_WIDTH-1:0]     fifo_di,
  output logic                      fifo_wren,
  output logic                      fifo_rden,
  output logic                      fifo_rst,
  input  logic [DATA_WIDTH-1:0]     fifo_do,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      almost_full
);
  localparam int CW = cnt_w(DEPTH);

  logic          fifo_rst_q, fifo_rst_d;
  logic [CW-1:0] count_q, count_d;
  logic          afull_q, afull_d;
  logic          busy, full, empty, wr, rd, m_valid;
  logic [1:0]    req, rdy;
  src_e          sel;

  // While the FIFO is in reset its pointers are unknown-to-us, so all handshakes stall.
  assign busy  = fifo_rst_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign req   = {bus.s1_valid, bus.s0_valid};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .en    (!busy && !full),
    .req   (req),
    .rdy   (rdy),
    .sel   (sel)
  );

  assign wr           = |(req & rdy);
  assign m_valid      = !busy && !empty;
  assign rd           = m_valid && bus.m_ready;

  assign bus.s0_ready = rdy[0];
  assign bus.s1_ready = rdy[1];
  assign bus.m_valid  = m_valid;
  assign bus.m_data   = fifo_do;

  assign fifo_di      = (sel == SRC1) ? bus.s1_data : bus.s0_data;
  assign fifo_wren    = wr;
  assign fifo_rden    = rd;
  assign fifo_rst     = fifo_rst_q;
  assign count        = count_q;
  assign almost_full  = afull_q;

  always_comb begin
    fifo_rst_d = flush;
    count_d    = count_q + CW'(wr) - CW'(rd);
    afull_d    = (count_d >= CW'(AFULL_THRESH));
    // Handshakes in the flush cycle still complete at the ports; the FIFO reset discards them.
    if (flush) begin
      count_d = '0;
      afull_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rst_q <= 1'b1;
      count_q    <= '0;
      afull_q    <= 1'b0;
    end else begin
      fifo_rst_q <= fifo_rst_d;
      count_q    <= count_d;
      afull_q    <= afull_d;
    end
  end
endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl with an attached circular-buffer FIFO model (DEPTH=8).
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int CW    = cnt_w(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] fifo_di, fifo_do;
  logic          fifo_wren, fifo_rden, fifo_rst;
  logic [CW-1:0] count;
  logic          almost_full;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];

  logic [DW-1:0] rr_s0 [4] = '{16'h00A0, 16'h00A1, 16'h00A1, 16'h00A2};
  logic [DW-1:0] rr_s1 [4] = '{16'h00B0, 16'h00B0, 16'h00B1, 16'h00B1};
  logic          rr_g0 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus),
    .fifo_di     (fifo_di),
    .fifo_wren   (fifo_wren),
    .fifo_rden   (fifo_rden),
    .fifo_rst    (fifo_rst),
    .fifo_do     (fifo_do),
    .count       (count),
    .almost_full (almost_full)
  );

  // Flagless circular-buffer FIFO with combinational read data.
  logic [DW-1:0] mem [DEPTH];
  logic [2:0]    wp, rp;
  assign fifo_do = mem[rp];
  always @(posedge clk) begin
    if (fifo_rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (fifo_wren) begin
        mem[wp] <= fifo_di;
        wp      <= wp + 3'd1;
      end
      if (fifo_rden) rp <= rp + 3'd1;
    end
  end

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumer monitor: every accepted word must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %0h expected nothing at %0t", bus.m_data, $time);
      end else begin
        chkv("m_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s0_data = '0; bus.s0_valid = 1'b0;
    bus.s1_data = '0; bus.s1_valid = 1'b0;
    bus.m_ready = 1'b0;

    // Reset and release
    repeat (3) begin
      tick();
      chkb("rst_fifo_rst", fifo_rst, 1'b1);
      chkv("rst_count", 32'(count), 0);
      chkb("rst_m_valid", bus.m_valid, 1'b0);
      chkb("rst_s0_ready", bus.s0_ready, 1'b0);
    end
    rst_n = 1'b1;
    #1;
    chkb("rel_fifo_rst_hold", fifo_rst, 1'b1);
    chkb("rel_s1_ready_hold", bus.s1_ready, 1'b0);
    tick();
    chkb("rel_fifo_rst_clear", fifo_rst, 1'b0);
    chkb("rel_s0_ready", bus.s0_ready, 1'b1);
    chkb("rel_m_valid", bus.m_valid, 1'b0);
    chkb("rel_afull", almost_full, 1'b0);

    // Fill: 1..9 from s0, consumer stalled
    bus.s0_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      bus.s0_data = DW'(i);
      #1;
      chkb("fill_s0_ready", bus.s0_ready, (i <= 8));
      if (i <= 8) exp_q.push_back(DW'(i));
      tick();
      chkv("fill_count", 32'(count), (i <= 8) ? i : 8);
      chkb("fill_afull", almost_full, (((i <= 8) ? i : 8) >= AF));
    end

    // Drain 1..8, then 9 passes through
    bus.s0_valid = 1'b0;
    bus.m_ready  = 1'b1;
    for (int k = 8; k >= 1; k--) begin
      #1;
      chkb("drain_m_valid", bus.m_valid, 1'b1);
      tick();
      chkv("drain_count", 32'(count), k - 1);
    end
    chkb("drain_empty", bus.m_valid, 1'b0);
    chkb("drain_afull", almost_full, 1'b0);
    bus.s0_data  = DW'(9);
    bus.s0_valid = 1'b1;
    exp_q.push_back(DW'(9));
    #1;
    chkb("nine_ready", bus.s0_ready, 1'b1);
    tick();
    bus.s0_valid = 1'b0;
    #1;
    chkb("nine_m_valid", bus.m_valid, 1'b1);
    tick();
    chkv("nine_count", 32'(count), 0);

    // Round-robin with both valid, consumer stalled
    bus.m_ready  = 1'b0;
    bus.s0_valid = 1'b1;
    bus.s1_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bus.s0_data = rr_s0[j];
      bus.s1_data = rr_s1[j];
      #1;
      chkb("rr_s0_ready", bus.s0_ready, rr_g0[j]);
      chkb("rr_s1_ready", bus.s1_ready, !rr_g0[j]);
      exp_q.push_back(rr_g0[j] ? rr_s0[j] : rr_s1[j]);
      tick();
    end
    bus.s0_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      bus.s1_data = DW'(16'h00B2 + j);
      #1;
      chkb("solo_s1_ready", bus.s1_ready, 1'b1);
      exp_q.push_back(DW'(16'h00B2 + j));
      tick();
    end
    // prio must still favour s0 after solo s1 grants
    bus.s0_valid = 1'b1;
    bus.s0_data  = 16'h00A2;
    bus.s1_data  = 16'h00B5;
    #1;
    chkb("prio_hold_s0", bus.s0_ready, 1'b1);
    chkb("prio_hold_s1", bus.s1_ready, 1'b0);
    exp_q.push_back(16'h00A2);
    tick();
    bus.s1_valid = 1'b0;
    chkv("rr_count", 32'(count), 8);
    chkb("rr_afull", almost_full, 1'b1);

    // Full with concurrent read: write waits for count 7
    bus.s0_data = 16'h00A3;
    bus.m_ready = 1'b1;
    #1;
    chkb("full_block", bus.s0_ready, 1'b0);
    tick();
    chkv("full_count7", 32'(count), 7);
    chkb("full_unblock", bus.s0_ready, 1'b1);
    exp_q.push_back(16'h00A3);
    tick();
    chkv("full_rw_count", 32'(count), 7);
    bus.s0_valid = 1'b0;
    repeat (3) tick();
    chkv("to4_count", 32'(count), 4);

    // Simultaneous read/write at count 4
    bus.s0_valid = 1'b1;
    bus.s0_data  = 16'h00C0;
    exp_q.push_back(16'h00C0);
    tick();
    chkv("rw_count_a", 32'(count), 4);
    bus.s0_data = 16'h00C1;
    exp_q.push_back(16'h00C1);
    tick();
    chkv("rw_count_b", 32'(count), 4);
    bus.s0_valid = 1'b0;
    repeat (4) tick();
    chkv("rw_drained", 32'(count), 0);

    // Build count 5 (last write contended so prio ends at s1), then flush
    bus.m_ready  = 1'b0;
    bus.s0_valid = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      bus.s0_data = DW'(16'h00D0 + j);
      exp_q.push_back(DW'(16'h00D0 + j));
      tick();
    end
    bus.s1_valid = 1'b1;
    bus.s0_data  = 16'h00D5;
    bus.s1_data  = 16'h00D9;
    exp_q.push_back(16'h00D5);
    tick();
    chkv("pre_flush_count", 32'(count), 5);
    bus.s1_valid = 1'b0;
    bus.s0_data  = 16'h00D6;
    flush        = 1'b1;
    #1;
    chkb("flush_write_ack", bus.s0_ready, 1'b1);
    tick();
    exp_q.delete();
    flush        = 1'b0;
    bus.s0_data  = 16'h00E0;
    bus.s1_data  = 16'h00E9;
    bus.s1_valid = 1'b1;
    #1;
    chkb("flush_fifo_rst", fifo_rst, 1'b1);
    chkv("flush_count", 32'(count), 0);
    chkb("flush_m_valid", bus.m_valid, 1'b0);
    chkb("flush_busy_s0", bus.s0_ready, 1'b0);
    tick();
    chkb("flush_rst_clear", fifo_rst, 1'b0);
    chkb("flush_prio_s0", bus.s0_ready, 1'b1);
    chkb("flush_prio_s1", bus.s1_ready, 1'b0);
    exp_q.push_back(16'h00E0);
    tick();
    chkb("post_flush_s1", bus.s1_ready, 1'b1);
    exp_q.push_back(16'h00E9);
    tick();
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    bus.m_ready  = 1'b1;
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) tick();
    chkv("post_flush_drained", 32'(exp_q.size()), 0);
    chkv("post_flush_count", 32'(count), 0);

    // Asynchronous reset mid-operation
    bus.m_ready  = 1'b0;
    bus.s0_valid = 1'b1;
    bus.s0_data  = 16'h00F0;
    tick();
    bus.s0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chkv("arst_count", 32'(count), 0);
    chkb("arst_fifo_rst", fifo_rst, 1'b1);
    chkb("arst_m_valid", bus.m_valid, 1'b0);
    chkb("arst_afull", almost_full, 1'b0);
    exp_q.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Control and arbitration shell for the single-clock circular-buffer FIFO (DATA_WIDTH x DEPTH; wren/rden pointer advance, combinational DO at read pointer, synchronous active-high rst; no full/empty flags).
- Arbitrates two producer streams (valid/ready) round-robin into the FIFO write port.
- Tracks occupancy and presents a valid/ready consumer stream from the FIFO read port.
- Generates the FIFO's reset/flush pulse; guarantees no write when full and no read when empty.

Parameters:
- DATA_WIDTH, 25, payload width; must match the FIFO instance.
- DEPTH, 256, FIFO entries; must match the FIFO instance; >=2.
- AFULL_THRESH, 240, almost_full asserts when count >= AFULL_THRESH; 1..DEPTH.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous reset, active-low
- flush  in  1  synchronous request to discard all FIFO contents
- s0_data  in  DATA_WIDTH  producer 0 payload
- s0_valid  in  1  producer 0 has data
- s0_ready  out  1  producer 0 transfer accepted this cycle when valid&ready
- s1_data / s1_valid / s1_ready  same as s0 for producer 1
- m_data  out  DATA_WIDTH  consumer payload (= fifo_do)
- m_valid  out  1  FIFO non-empty
- m_ready  in  1  consumer accepts m_data
- fifo_di  out  DATA_WIDTH  to FIFO DI
- fifo_wren  out  1  to FIFO wren
- fifo_rden  out  1  to FIFO rden
- fifo_rst  out  1  to FIFO rst (active-high, registered)
- fifo_do  in  DATA_WIDTH  from FIFO DO
- count  out  CW = clog2(DEPTH+1)  current occupancy, 0..DEPTH
- almost_full  out  1  count >= AFULL_THRESH (registered)

Behaviour:
- Reset (rst_n low, async): count=0, almost_full=0, prio=0, fifo_rst=1. Therefore m_valid=0, s0_ready=s1_ready=0, fifo_wren=fifo_rden=0.
- First rising clk after rst_n release: fifo_rst clears to 0; the FIFO sees its synchronous reset on that edge. Handshakes are enabled from the next cycle.
- busy = fifo_rst; full = (count==DEPTH); empty = (count==0).
- Arbitration (combinational):
  - s0_ready = !busy & !full & (!s1_valid | prio==0).
  - s1_ready = !busy & !full & (!s0_valid | prio==1).
  - A single requester is always granted.
  - When both are valid, the source selected by prio wins. prio then flips to the other source on that edge. prio is unchanged when only one source is valid.
- Write path: fifo_wren = (s0_valid&s0_ready) | (s1_valid&s1_ready); fifo_di = granted source's data (s0_data when no grant).
- Read path: m_valid = !busy & !empty; m_data = fifo_do; fifo_rden = m_valid & m_ready.
- Latency: a word written at edge N appears on m_data/m_valid after edge N (zero added latency; FIFO DO is combinational).
- Count: count_next = count + wr - rd.
  - Simultaneous wr and rd leaves count unchanged.
  - Full blocks writes even with a concurrent read (no write-through). Empty blocks reads (no bypass).
- almost_full is registered from count_next.
- Flush: flush sampled high at edge N gives fifo_rst=1, count=0, prio=0, almost_full=0 after edge N; fifo_rst=0 after edge N+1.
  - Any handshake completing in cycle N is honoured at the ports, but its data is discarded.
  - flush held high keeps fifo_rst high.
- Pointer wrap is handled inside the FIFO. The controller never issues rden with count==0 or wren with count==DEPTH, so FIFO pointers never cross.
- Reset asserted mid-operation: all state returns to reset values immediately; outputs are as above.

Decomposition:
- Shared package: clog2 function, CW derivation, default DATA_WIDTH/DEPTH constants (also used by fifo instances).
- One natural sub-module: rr_arb2 (2-way round-robin grant plus prio register), instantiated once. Counter, flush and handshake logic stay in fifo_ctrl.

Test Plan:
- Reset release:
  - Stimulus: rst_n low 3 cycles, then high.
  - Required: fifo_rst=1 during reset and until the first edge after release, then 0. count=0, m_valid=0, readies=0 until fifo_rst=0.
- Fill to full (DEPTH=8, AFULL_THRESH=6, FIFO model attached):
  - Stimulus: s0 writes 1..9 back-to-back, m_ready=0.
  - Required: 8 accepted. almost_full rises when count reaches 6. s0_ready=0 at count=8. Value 9 is held.
- Drain:
  - Stimulus: continue with m_ready=1.
  - Required: m_data 1..8 in order. count 8→0. m_valid drops when count reaches 0. Afterwards 9 is written and read.
- Round-robin:
  - Stimulus: s0 and s1 both continuously valid, s0=0xA0.., s1=0xB0...
  - Required: grants alternate s0,s1,s0,s1 from reset (prio=0). With only s1 valid, s1 is granted every cycle and prio does not flip.
- Simultaneous read/write at count=4:
  - Stimulus: wr and rd in the same cycle.
  - Required: count stays 4; order preserved. At count=8 with m_ready=1, writes remain blocked until count=7.
- Flush mid-stream at count=5, with a concurrent write:
  - Stimulus: assert flush for one cycle.
  - Required: the write is acknowledged. Next cycle fifo_rst=1, count=0, m_valid=0. The following cycle handshakes resume and the first new word emerges first.
